// File: rtl/usbf_utmi_phy_pkg.sv
// Shared encodings for the UTMI PHY model: TX/RX state enums, OpMode values
// and the counter-width helper.
package usbf_utmi_phy_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SYNC = 2'd1,
    TX_DATA = 2'd2,
    TX_EOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_ACTIVE = 2'd1,
    RX_ERR    = 2'd2
  } rx_state_t;

  localparam logic [1:0] OPMODE_NORMAL = 2'b00;
  localparam logic [1:0] OPMODE_NONDRV = 2'b01;
  localparam logic [1:0] OPMODE_RAW    = 2'b10;

  // Smallest width (at least 1) that can hold max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((2 ** w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/usbf_utmi_phy_if.sv
// Link-side UTMI signal bundle; master = link controller, slave = PHY.
interface usbf_utmi_phy_if;
  logic [7:0] DataOut;
  logic       TxValid;
  logic       TxReady;
  logic [7:0] DataIn;
  logic       RxValid;
  logic       RxActive;
  logic       RxError;
  logic       XcvSelect;
  logic       TermSel;
  logic       SuspendM;
  logic [1:0] OpMode;
  logic [1:0] LineState;

  modport master (
    output DataOut, TxValid, XcvSelect, TermSel, SuspendM, OpMode,
    input  TxReady, DataIn, RxValid, RxActive, RxError, LineState
  );

  modport slave (
    input  DataOut, TxValid, XcvSelect, TermSel, SuspendM, OpMode,
    output TxReady, DataIn, RxValid, RxActive, RxError, LineState
  );
endinterface

// File: rtl/usbf_utmi_phy_rx.sv
// Receive path: frames line-side bytes into DataIn/RxValid/RxActive/RxError.
// state     | meaning
// RX_IDLE   | waiting for sop (ignored while tx_block)
// RX_ACTIVE | packet in progress, bytes forwarded with 1-cycle latency
// RX_ERR    | one-cycle error indication, then back to idle
module usbf_utmi_phy_rx
  import usbf_utmi_phy_pkg::*;
(
  input  logic       phy_clk,
  input  logic       rst,
  input  logic       suspend_m,
  input  logic       tx_block,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       sop,
  input  logic       eop,
  input  logic       err,
  output logic [7:0] data_in,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error
);

  rx_state_t rx_state;

  always_ff @(posedge phy_clk or negedge rst) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      data_in   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!suspend_m) begin
        rx_state  <= RX_IDLE;
        rx_active <= 1'b0;
        rx_error  <= 1'b0;
      end else begin
        case (rx_state)
          RX_IDLE: begin
            rx_error <= 1'b0;
            if (sop && !tx_block) begin
              rx_state  <= RX_ACTIVE;
              rx_active <= 1'b1;
            end
          end
          RX_ACTIVE: begin
            // A byte coinciding with eop is still delivered; one with err is dropped.
            if (byte_valid && !err) begin
              rx_valid <= 1'b1;
              data_in  <= byte_data;
            end
            if (err) begin
              rx_state <= RX_ERR;
              rx_error <= 1'b1;
            end else if (eop) begin
              rx_state  <= RX_IDLE;
              rx_active <= 1'b0;
            end
          end
          RX_ERR: begin
            rx_state  <= RX_IDLE;
            rx_active <= 1'b0;
            rx_error  <= 1'b0;
          end
          default: begin
            rx_state  <= RX_IDLE;
            rx_active <= 1'b0;
            rx_error  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/usbf_utmi_phy.sv
// UTMI PHY behavioural top: TX FSM with SYNC/EOP/FS pacing plus RX sub-module.
// Optional TX->RX loopback when USBF_UTMI_PHY_LOOPBACK_EN is defined.
// state   | meaning
// TX_IDLE | no packet; waits for a fresh TxValid
// TX_SYNC | SYNC_CYCLES of sync pattern, TxReady low
// TX_DATA | byte transfer, TxReady every cycle (HS) or paced by FS_GAP (FS)
// TX_EOP  | EOP_CYCLES of end-of-packet, TxReady low
module usbf_utmi_phy
  import usbf_utmi_phy_pkg::*;
#(
  parameter int SYNC_CYCLES = 4,
  parameter int EOP_CYCLES  = 2,
  parameter int FS_GAP      = 3
) (
  input  logic           phy_clk,
  input  logic           rst,
  usbf_utmi_phy_if.slave utmi,
  output logic [7:0]     ser_tx_data,
  output logic           ser_tx_valid,
  output logic           ser_tx_sop,
  output logic           ser_tx_eop,
  input  logic [7:0]     ser_rx_data,
  input  logic           ser_rx_valid,
  input  logic           ser_rx_sop,
  input  logic           ser_rx_eop,
  input  logic           ser_rx_err,
  input  logic [1:0]     line_state_i
);

  localparam int CNT_MAX = (SYNC_CYCLES > EOP_CYCLES)
                         ? ((SYNC_CYCLES > FS_GAP) ? SYNC_CYCLES : FS_GAP)
                         : ((EOP_CYCLES > FS_GAP) ? EOP_CYCLES : FS_GAP);
  localparam int CW = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] SYNC_LOAD = CW'(SYNC_CYCLES);
  localparam logic [CW-1:0] EOP_LOAD  = CW'(EOP_CYCLES);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(FS_GAP);
  localparam logic [CW-1:0] ONE       = CW'(1);

  tx_state_t   tx_state;
  logic [CW-1:0] cnt;
  logic        tx_ready;
  logic        tx_arm;
  logic        pkt_raw;
  logic        tx_raw;
  logic        tx_start;
  logic        xfer;
  logic [1:0]  line_state_q;

  logic [7:0]  rx_byte_data;
  logic        rx_byte_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_err;
  logic        rx_tx_block;
  logic [7:0]  rx_data_in;
  logic        rx_valid;
  logic        rx_active;
  logic        rx_error;

  assign tx_raw   = (utmi.OpMode == OPMODE_RAW);
  assign tx_start = (tx_state == TX_IDLE) && utmi.TxValid && tx_arm && utmi.SuspendM &&
                    ((utmi.OpMode == OPMODE_NORMAL) || tx_raw);
  assign xfer     = (tx_state == TX_DATA) && utmi.TxValid && tx_ready;

  always_ff @(posedge phy_clk or negedge rst) begin
    if (!rst) begin
      tx_state     <= TX_IDLE;
      cnt          <= '0;
      tx_ready     <= 1'b0;
      tx_arm       <= 1'b0;
      pkt_raw      <= 1'b0;
      ser_tx_data  <= 8'h00;
      ser_tx_valid <= 1'b0;
      ser_tx_sop   <= 1'b0;
      ser_tx_eop   <= 1'b0;
    end else begin
      ser_tx_sop   <= 1'b0;
      ser_tx_eop   <= 1'b0;
      ser_tx_valid <= xfer;
      if (xfer) ser_tx_data <= utmi.DataOut;
      // A new packet needs TxValid to have been low since reset, suspend or the last start.
      tx_arm <= !utmi.TxValid || (tx_arm && utmi.SuspendM && !tx_start);
      if (!utmi.SuspendM) begin
        tx_state     <= TX_IDLE;
        tx_ready     <= 1'b0;
        ser_tx_valid <= 1'b0;
        cnt          <= '0;
      end else begin
        case (tx_state)
          TX_IDLE: begin
            tx_ready <= 1'b0;
            if (tx_start) begin
              pkt_raw    <= tx_raw;
              cnt        <= tx_raw ? '0 : SYNC_LOAD;
              tx_state   <= tx_raw ? TX_DATA : TX_SYNC;
              ser_tx_sop <= !tx_raw;
            end
          end
          TX_SYNC: begin
            if (cnt <= ONE) begin
              tx_state <= TX_DATA;
              cnt      <= '0;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          TX_DATA: begin
            if (!utmi.TxValid) begin
              tx_ready <= 1'b0;
              if (pkt_raw) begin
                tx_state <= TX_IDLE;
                cnt      <= '0;
              end else begin
                tx_state   <= TX_EOP;
                cnt        <= EOP_LOAD;
                ser_tx_eop <= 1'b1;
              end
            end else if (!utmi.XcvSelect) begin
              tx_ready <= 1'b1;
            end else if (tx_ready) begin
              tx_ready <= 1'b0;
              cnt      <= GAP_LOAD;
            end else if (cnt <= ONE) begin
              tx_ready <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          TX_EOP: begin
            if (cnt <= ONE) begin
              tx_state <= TX_IDLE;
              cnt      <= '0;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          default: begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b0;
            cnt      <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge phy_clk or negedge rst) begin
    if (!rst) line_state_q <= 2'b00;
    else      line_state_q <= line_state_i;
  end

`ifdef USBF_UTMI_PHY_LOOPBACK_EN
  logic tx_done;
  logic lb_end;

  // RxActive opens with TX start and closes one cycle after the last EOP cycle.
  assign tx_done = ((tx_state == TX_EOP) && (cnt <= ONE)) ||
                   ((tx_state == TX_DATA) && pkt_raw && !utmi.TxValid);

  always_ff @(posedge phy_clk or negedge rst) begin
    if (!rst) lb_end <= 1'b0;
    else      lb_end <= tx_done;
  end

  assign rx_byte_data  = ser_tx_data;
  assign rx_byte_valid = ser_tx_valid;
  assign rx_sop        = tx_start;
  assign rx_eop        = lb_end;
  assign rx_err        = 1'b0;
  assign rx_tx_block   = 1'b0;
`else
  assign rx_byte_data  = ser_rx_data;
  assign rx_byte_valid = ser_rx_valid;
  assign rx_sop        = ser_rx_sop;
  assign rx_eop        = ser_rx_eop;
  assign rx_err        = ser_rx_err;
  assign rx_tx_block   = (tx_state != TX_IDLE) || tx_start;
`endif

  usbf_utmi_phy_rx u_rx (
    .phy_clk    (phy_clk),
    .rst        (rst),
    .suspend_m  (utmi.SuspendM),
    .tx_block   (rx_tx_block),
    .byte_data  (rx_byte_data),
    .byte_valid (rx_byte_valid),
    .sop        (rx_sop),
    .eop        (rx_eop),
    .err        (rx_err),
    .data_in    (rx_data_in),
    .rx_valid   (rx_valid),
    .rx_active  (rx_active),
    .rx_error   (rx_error)
  );

  assign utmi.TxReady   = tx_ready;
  assign utmi.DataIn    = rx_data_in;
  assign utmi.RxValid   = rx_valid;
  assign utmi.RxActive  = rx_active;
  assign utmi.RxError   = rx_error;
  assign utmi.LineState = line_state_q;

endmodule
